// File: rtl/mem_responder.sv
// Word-addressed RAM answering MAR/MDR memory strobes with a fixed number of
// wait cycles, a one-cycle MemDone pulse on completion and MemErr on conflict.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] MAR_addr,
  input  logic [DATA_WIDTH-1:0] MDR_data,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  MemBusy,
  output logic                  MemDone,
  output logic                  MemErr,
  output logic [1:0]            dbg_state
);

  // Handshake: Read/Write are level requests sampled only in IDLE; the
  // requester must drop its strobe in the cycle MemDone is high, otherwise
  // the still-high strobe is taken as a fresh request one cycle later.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    is_write_q;
  logic [DATA_WIDTH-1:0]   mdatain_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic                    commit;

  assign commit = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
      mdatain_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Read && Write) begin
            err_q <= 1'b1;
          end else if (Read || Write) begin
            addr_q     <= MAR_addr;
            data_q     <= MDR_data;
            is_write_q <= Write;
            cnt_q      <= CNT_INIT;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!is_write_q) begin
              mdatain_q <= mem[addr_q];
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The array has no reset; the clear gate stops a write racing a reset edge.
  always_ff @(posedge clock) begin
    if (commit && is_write_q && !clear) begin
      mem[addr_q] <= data_q;
    end
  end

  assign Mdatain   = mdatain_q;
  assign MemBusy   = busy_q;
  assign MemDone   = done_q;
  assign MemErr    = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES 1 and 3), a vector table,
// hand-written corner sequences and random traffic against a memory model.
module tb_mem_responder;

  logic        clock;
  logic        clr   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [8:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] mdat  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];
  logic [1:0]  dbg   [2];

  int wc [2] = '{1, 3};

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [int];
  logic [31:0] mdat_m [2];

  typedef struct {
    int          dev;
    bit          is_rd;
    logic [8:0]  a;
    logic [31:0] wd;
    bit          disturb;
    logic [31:0] exp;
  } vec_t;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(1)) u_w1 (
    .clock(clock), .clear(clr[0]), .Read(rd[0]), .Write(wr[0]),
    .MAR_addr(addr[0]), .MDR_data(wdata[0]), .Mdatain(mdat[0]),
    .MemBusy(busy[0]), .MemDone(done[0]), .MemErr(err[0]), .dbg_state(dbg[0])
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(3)) u_w3 (
    .clock(clock), .clear(clr[1]), .Read(rd[1]), .Write(wr[1]),
    .MAR_addr(addr[1]), .MDR_data(wdata[1]), .Mdatain(mdat[1]),
    .MemBusy(busy[1]), .MemDone(done[1]), .MemErr(err[1]), .dbg_state(dbg[1])
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic int key(input int d, input logic [8:0] a);
    return d * 1024 + int'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One full access; disturb scrambles address/data right after acceptance.
  task automatic access(input int d, input bit is_rd, input logic [8:0] a,
                        input logic [31:0] wd, input bit disturb,
                        output logic [31:0] obs);
    int busy_n;
    bit got;
    logic [31:0] exp_rd;
    exp_rd = mdat_m[d];
    if (is_rd && mm.exists(key(d, a))) exp_rd = mm[key(d, a)];
    @(negedge clock);
    rd[d] = is_rd; wr[d] = !is_rd; addr[d] = a; wdata[d] = wd;
    @(negedge clock);
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (disturb) begin
      addr[d]  = a + 9'd1;
      wdata[d] = 32'h0000_00FF;
    end
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done[d]) got = 1'b1;
      else begin
        if (busy[d]) busy_n++;
        @(negedge clock);
      end
    end
    obs = mdat[d];
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", 32'(busy_n), 32'(wc[d]));
    check("busy_in_done", 32'(busy[d]), 32'd0);
    check("mdatain_at_done", mdat[d], exp_rd);
    if (is_rd) mdat_m[d] = exp_rd;
    else mm[key(d, a)] = wd;
    @(negedge clock);
    check("done_pulse_width", 32'(done[d]), 32'd0);
    check("idle_busy", 32'(busy[d]), 32'd0);
  endtask

  task automatic reject(input int d, input logic [8:0] a);
    @(negedge clock);
    rd[d] = 1'b1; wr[d] = 1'b1; addr[d] = a; wdata[d] = 32'hBAD0_BAD0;
    @(negedge clock);
    rd[d] = 1'b0; wr[d] = 1'b0;
    check("err_pulse", 32'(err[d]), 32'd1);
    check("err_no_busy", 32'(busy[d]), 32'd0);
    check("err_mdatain", mdat[d], mdat_m[d]);
    @(negedge clock);
    check("err_width", 32'(err[d]), 32'd0);
    check("err_no_busy2", 32'(busy[d]), 32'd0);
    check("err_no_done", 32'(done[d]), 32'd0);
  endtask

  task automatic hold_read(input int d, input logic [8:0] a);
    int w;
    int idx[$];
    w = wc[d];
    @(negedge clock);
    rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = a;
    for (int i = 0; i < 3 * (w + 2); i++) begin
      @(negedge clock);
      if (done[d]) begin
        idx.push_back(i);
        check("hold_rdata", mdat[d], mm[key(d, a)]);
      end
    end
    rd[d] = 1'b0;
    mdat_m[d] = mm[key(d, a)];
    check("hold_count", 32'(idx.size()), 32'd3);
    if (idx.size() == 3) begin
      check("hold_first", 32'(idx[0]), 32'(w));
      check("hold_space1", 32'(idx[1] - idx[0]), 32'(w + 2));
      check("hold_space2", 32'(idx[2] - idx[1]), 32'(w + 2));
    end
    @(negedge clock);
    check("hold_end_idle", 32'(busy[d] | done[d]), 32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] obs;
    logic [8:0]  pool [8];

    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; mdat_m[d] = '0;
    end

    tbl.push_back('{0, 1'b0, 9'h005, 32'h0000_0012, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 9'h005, 32'h0,         1'b0, 32'h0000_0012});
    tbl.push_back('{1, 1'b0, 9'h000, 32'hA5A5_A5A5, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b0, 9'h1FF, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b1, 9'h1FF, 32'h0,         1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{1, 1'b1, 9'h000, 32'h0,         1'b0, 32'hA5A5_A5A5});
    tbl.push_back('{0, 1'b0, 9'h010, 32'h0000_0055, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 9'h021, 32'h0000_0077, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 9'h020, 32'h0000_0014, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 9'h020, 32'h0,         1'b0, 32'h0000_0014});
    tbl.push_back('{0, 1'b1, 9'h021, 32'h0,         1'b0, 32'h0000_0077});

    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("rst_mdatain", mdat[d], 32'h0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_done", 32'(done[d]), 32'd0);
      check("rst_err", 32'(err[d]), 32'd0);
    end
    clr[0] = 1'b0; clr[1] = 1'b0;

    foreach (tbl[i]) begin
      access(tbl[i].dev, tbl[i].is_rd, tbl[i].a, tbl[i].wd, tbl[i].disturb, obs);
      if (tbl[i].is_rd) check("tbl_rdata", obs, tbl[i].exp);
    end

    // conflicting strobes leave memory and read data alone
    reject(0, 9'h010);
    access(0, 1'b1, 9'h010, 32'h0, 1'b0, obs);
    check("after_reject_mem", obs, 32'h0000_0055);

    // reset in the middle of a write aborts it
    access(1, 1'b0, 9'h030, 32'h0000_0011, 1'b0, obs);
    @(negedge clock);
    wr[1] = 1'b1; addr[1] = 9'h030; wdata[1] = 32'h0000_0018;
    @(negedge clock);
    wr[1] = 1'b0;
    check("pre_clear_busy", 32'(busy[1]), 32'd1);
    #1 clr[1] = 1'b1;
    #1;
    check("clr_mdatain", mdat[1], 32'h0);
    check("clr_busy", 32'(busy[1]), 32'd0);
    check("clr_done", 32'(done[1]), 32'd0);
    check("clr_err", 32'(err[1]), 32'd0);
    @(negedge clock);
    clr[1] = 1'b0;
    mdat_m[1] = '0;
    access(1, 1'b1, 9'h030, 32'h0, 1'b0, obs);
    check("clear_abort_mem", obs, 32'h0000_0011);

    hold_read(0, 9'h005);
    hold_read(1, 9'h1FF);

    for (int i = 0; i < 8; i++) pool[i] = 9'(9'h100 + i);
    for (int n = 0; n < 40; n++) begin
      int d;
      logic [8:0] a;
      d = int'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 7)];
      if (!mm.exists(key(d, a)) || $urandom_range(0, 1) == 0)
        access(d, 1'b0, a, $urandom, 1'b0, obs);
      else
        access(d, 1'b1, a, 32'h0, 1'b0, obs);
    end

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed synchronous RAM that answers the CPU datapath's memory strobes. It sits on the memory side of the MAR/MDR interface: it samples `Read`/`Write` with the MAR address and MDR write data, and after a programmable number of wait cycles it returns read data on `Mdatain` together with a one-cycle `MemDone` pulse. The control sequencer holds its memory T-state until `MemDone`, so real memory latency replaces hand-driven `Mdatain` stimulus.

## Interface

Parameters:
- `ADDR_WIDTH`, 9: word address width; depth = 2^ADDR_WIDTH (512 words).
- `DATA_WIDTH`, 32: word width.
- `WAIT_CYCLES`, 1: clock edges from request acceptance to access commit. Legal range is 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clock`, in, 1: rising-edge clock.
- `clear`, in, 1: asynchronous, active-high reset.
- `Read`, in, 1: read request strobe, level-sensitive.
- `Write`, in, 1: write request strobe, level-sensitive.
- `MAR_addr`, in, ADDR_WIDTH: word address, taken from the low bits of MAR.
- `MDR_data`, in, DATA_WIDTH: write data from MDR.
- `Mdatain`, out, DATA_WIDTH: read data to the MDR input mux. Registered.
- `MemBusy`, out, 1: high while an access is in flight.
- `MemDone`, out, 1: one-cycle pulse when an access completes.
- `MemErr`, out, 1: one-cycle pulse when a request is rejected.

## Operation

- States are IDLE, ACCESS and DONE. The state register, counter `cnt` (4 bits) and all outputs are registered.
- IDLE:
  - If exactly one of `Read`/`Write` is high at a rising edge, latch `MAR_addr`, `MDR_data` and the operation type. Load `cnt = WAIT_CYCLES-1` and go to ACCESS.
  - If both are high, reject the request. Pulse `MemErr` for one cycle, stay in IDLE, and change neither memory nor `Mdatain`.
  - If neither is high, stay in IDLE.
- ACCESS:
  - `MemBusy`=1.
  - If `cnt`≠0, decrement it.
  - If `cnt`=0, commit the access and go to DONE:
    - a read loads `mem[addr]` into `Mdatain`;
    - a write stores the latched data into `mem[addr]`, and `Mdatain` is unchanged.
  - Changes on `Read`, `Write`, `MAR_addr` or `MDR_data` during ACCESS are ignored; the values latched at acceptance are used.
- DONE:
  - `MemDone`=1 and `MemBusy`=0.
  - Strobes are ignored. Next state is always IDLE.
- Strobes are level-sensitive. A strobe still high on return to IDLE starts a new access, so the sequencer must drop it on the cycle `MemDone` is seen.
- `Mdatain` holds the last read value until the next read commits.
- Addresses cover the full 0..2^ADDR_WIDTH-1 range with no out-of-range case. MAR bits above ADDR_WIDTH are not connected.
- Reset (`clear`=1, asynchronous):
  - state=IDLE, `cnt`=0, `Mdatain`=0, `MemBusy`=0, `MemDone`=0, `MemErr`=0.
  - Array contents are not cleared.
  - A write in flight is aborted with no commit.
  - After `clear` falls, the first rising edge may accept a request.

## Timing

- The request is accepted at edge k. The commit happens at edge k+WAIT_CYCLES.
- `MemBusy` is high from edge k to edge k+WAIT_CYCLES.
- `MemDone` is high from edge k+WAIT_CYCLES to edge k+WAIT_CYCLES+1.
- Read data is valid on `Mdatain` in the same cycle `MemDone` is high. The sequencer asserts `MDRin` that cycle and the MDR captures at edge k+WAIT_CYCLES+1.
- Minimum spacing between acceptances is WAIT_CYCLES+2 edges (one ACCESS span, one DONE cycle, re-accept from IDLE).
- `MemErr` is high for the cycle after the rejecting edge.
- Read-after-write to the same address returns the new data: the write commits before the read can be accepted.

## Test plan

- Reset, then Write addr 0x005 data 0x00000012 → `MemDone` pulse one edge after acceptance (WAIT_CYCLES=1). Then Read addr 0x005 → `Mdatain`=0x00000012 in the `MemDone` cycle, `MemBusy` high exactly one cycle.
- WAIT_CYCLES=3: Read addr 0x1FF after a write of 0xDEADBEEF → `MemBusy` high 3 cycles, `MemDone` at edge k+3, `Mdatain`=0xDEADBEEF. Address 0x000 is unaffected.
- `Read`=`Write`=1 with addr 0x010 → `MemErr` one-cycle pulse, no `MemBusy`, mem[0x010] and `Mdatain` unchanged.
- Write 0x14 to addr 0x020, and change `MAR_addr` to 0x021 and `MDR_data` to 0xFF during ACCESS → mem[0x020]=0x14 and mem[0x021] unchanged.
- WAIT_CYCLES=3: start Write 0x18 to addr 0x030 over old value 0x11, pulse `clear` mid-ACCESS → all outputs 0 immediately, mem[0x030] still 0x11, and the next Read returns 0x11.
- Hold `Read` high continuously at addr 0x005 → accesses repeat every WAIT_CYCLES+2 edges, with one `MemDone` per access and IDLE for exactly one cycle between them.
